pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 10: width of the period, high-time and low-time counters.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000: cycles without an edge before the input is declared stuck.
REQ-003 SHALL have port clk_1m, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_in, input, 1: PWM line, asynchronous to clk_1m.
REQ-006 SHALL have port period, output, CNT_W: last measured period in cycles.
REQ-007 SHALL have port high_cnt, output, CNT_W: last measured high time in cycles.
REQ-008 SHALL have port low_cnt, output, CNT_W: last measured low time in cycles.
REQ-009 SHALL have port level, output, 4: decoded duty level.
REQ-010 SHALL have port meas_valid, output, 1: one-cycle pulse when new results are published.
REQ-011 SHALL have port stuck, output, 1: no edge seen within TIMEOUT_CYC.
REQ-012 SHALL have port stuck_level, output, 1: synchronized line value captured when the stuck timeout fires.

Function
REQ-013 SHALL pass pwm_in through a 2-flop synchronizer, then a registered edge detector; pin-to-detected-edge latency is 3 cycles.
REQ-014 SHALL implement states ST_IDLE, ST_HIGH and ST_LOW.
REQ-015 ST_IDLE: on a rising edge, go to ST_HIGH and set the high counter to 1; a falling edge is ignored.
REQ-016 ST_HIGH: increment the high counter each cycle; on a falling edge, go to ST_LOW and set the low counter to 1.
REQ-017 ST_LOW: increment the low counter each cycle; on a rising edge, do all of the following:
- publish high_cnt, low_cnt and period = high + low (saturating);
- compute level;
- pulse meas_valid on the next cycle;
- go to ST_HIGH with the high counter set to 1.
REQ-018 Counters and period SHALL saturate at 2^CNT_W-1; they never wrap.
REQ-019 level SHALL be the largest n in 0..15 with n*n <= low_cnt; low_cnt >= 225 gives 15.
REQ-020 The first rising edge after ST_IDLE SHALL NOT publish; the first publish needs a full rise-fall-rise cycle.
REQ-021 period, high_cnt, low_cnt and level SHALL hold their values between publishes.
REQ-022 meas_valid SHALL be high for exactly one cycle per publish.

Reset
REQ-023 On rst low, all of the following SHALL clear immediately, regardless of state: synchronizer, state (ST_IDLE), all counters, period, high_cnt, low_cnt, level, meas_valid, stuck and stuck_level.
REQ-024 After reset release, the block SHALL restart in ST_IDLE; a reset mid-measurement discards the partial counts.

Configuration
REQ-025 With PWM_CAPTURE_TIMEOUT_EN defined, an edge timer SHALL count cycles since the last detected edge (an edge in the same cycle wins and clears the timer).
REQ-026 When the edge timer reaches TIMEOUT_CYC, all of the following SHALL happen:
- stuck=1;
- stuck_level = synchronized line value;
- level = 0 if the line is stuck high, 15 if stuck low;
- state goes to ST_IDLE;
- no meas_valid pulse;
- period, high_cnt and low_cnt hold.
REQ-027 stuck SHALL clear on the next publish.
REQ-028 Without PWM_CAPTURE_TIMEOUT_EN, there SHALL be no edge timer; stuck and stuck_level are tied to 0.

Structure
REQ-029 Shared package pwm_pkg SHALL hold the state enum, the CNT_W default, and the 16-entry square table (0,1,4,...,225).
REQ-030 The level decode SHALL be a combinational sub-module pwm_isqrt: CNT_W-bit input, 4-bit output, implemented as a square-table compare.

Verification
REQ-031 Periodic input, period 256, low 9 / high 247, starting low:
- first meas_valid after the 2nd rising edge;
- period=256, low_cnt=9, high_cnt=247, level=3.
REQ-032 Input low 225 / high 31: level=15; low 224: level=14; low 0 cycles is covered by REQ-033.
REQ-033 With TIMEOUT_EN defined:
- input held high 1000 cycles -> stuck=1, stuck_level=1, level=0, no meas_valid;
- then a toggling input -> stuck=0 at the next publish.
REQ-034 rst asserted mid-high-phase -> all outputs 0 at once; after release, the next publish reflects only post-reset edges.
REQ-035 Input high 1200 / low 50 with CNT_W=10 -> high_cnt=1023 (saturated), period=1023.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding,
// default counter width and the square table used by the duty-level decode.
package pwm_pkg;

    // Default width of the period / high-time / low-time counters
    localparam int CNT_W_DEF = 10;

    // Width of the decoded duty level and number of square-table entries
    localparam int LVL_W = 4;
    localparam int SQ_N  = 16;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

    // Squares of 0..15; entry n holds n*n (index 0 is the rightmost element)
    localparam logic [SQ_N-1:0][7:0] SQ_TABLE = {
        8'd225, 8'd196, 8'd169, 8'd144,
        8'd121, 8'd100, 8'd81,  8'd64,
        8'd49,  8'd36,  8'd25,  8'd16,
        8'd9,   8'd4,   8'd1,   8'd0
    };

endpackage

// File: rtl/pwm_isqrt.sv
// Combinational integer square root, clipped to 0..15: returns the largest
// n with n*n <= x by comparing x against every entry of the square table.
module pwm_isqrt
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)(
    input  logic [CNT_W-1:0] x,
    output logic [LVL_W-1:0] root
);

    // Compare at no less than 8 bits so every table entry fits
    localparam int CMP_W = (CNT_W > 8) ? CNT_W : 8;

    logic [CMP_W-1:0] x_ext;
    logic [SQ_N-1:0]  ge;

    assign x_ext = CMP_W'(x);

    // One comparator per table entry; the result is a thermometer code
    genvar gi;
    generate
        for (gi = 0; gi < SQ_N; gi++) begin : g_cmp
            assign ge[gi] = (x_ext >= CMP_W'(SQ_TABLE[gi]));
        end
    endgenerate

    // Pick the highest entry that is still <= x
    always_comb begin
        root = '0;
        for (int i = 0; i < SQ_N; i++) begin
            if (ge[i]) begin
                root = LVL_W'(i);
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes an asynchronous PWM line, measures high time,
// low time and period in clk_1m cycles, and publishes them with a decoded
// duty level (integer square root of the low time) once per full period.
// Optional build macro PWM_CAPTURE_TIMEOUT_EN adds an edge timer that flags
// a stuck line after TIMEOUT_CYC cycles without an edge.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 1000
)(
    input  logic             clk_1m,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [3:0]       level,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Input conditioning
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic rise_reg;
    logic fall_reg;

    // Measurement FSM and running counters
    pwm_state_t       state_reg;
    pwm_state_t       state_next;
    logic [CNT_W-1:0] high_ctr_reg;
    logic [CNT_W-1:0] high_ctr_next;
    logic [CNT_W-1:0] low_ctr_reg;
    logic [CNT_W-1:0] low_ctr_next;
    logic             publish;
    logic             timeout_fire;

    // Published results
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] low_cnt_reg;
    logic [LVL_W-1:0] level_reg;
    logic             meas_valid_reg;

    // Derived values
    logic [CNT_W:0]   period_sum;
    logic [CNT_W-1:0] period_sat;
    logic [LVL_W-1:0] level_calc;

    // Two-flop synchronizer followed by a registered edge detector
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= pwm_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
            fall_reg  <= ~sync2_reg & prev_reg;
        end
    end

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam int               TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_BEFORE = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] tmr_reg;
    logic             any_edge;
    logic             stuck_reg;
    logic             stuck_level_reg;

    assign any_edge = rise_reg | fall_reg;

    // Fires exactly once, on the cycle the timer steps onto the limit
    assign timeout_fire = !any_edge && (tmr_reg == TMR_BEFORE);

    // Edge timer: cleared by any edge, otherwise counts up and parks at the limit
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            tmr_reg <= '0;
        end else if (any_edge) begin
            tmr_reg <= '0;
        end else if (tmr_reg != TMR_LIMIT) begin
            tmr_reg <= tmr_reg + 1'b1;
        end
    end

    // Stuck flag: set with the line value on timeout, cleared by the next publish
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            stuck_reg       <= 1'b0;
            stuck_level_reg <= 1'b0;
        end else if (publish) begin
            stuck_reg <= 1'b0;
        end else if (timeout_fire) begin
            stuck_reg       <= 1'b1;
            stuck_level_reg <= sync2_reg;
        end
    end

    assign stuck       = stuck_reg;
    assign stuck_level = stuck_level_reg;
`else
    assign timeout_fire = 1'b0;
    assign stuck        = 1'b0;
    assign stuck_level  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a timeout always sends the FSM back to idle
    always_comb begin
        state_next = state_reg;
        if (timeout_fire) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (rise_reg) state_next = ST_HIGH;
                ST_HIGH: if (fall_reg) state_next = ST_LOW;
                ST_LOW:  if (rise_reg) state_next = ST_HIGH;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Counter updates and publish strobe; the edge cycle itself is not counted,
    // so a counter started at 1 ends equal to the phase length in cycles
    always_comb begin
        high_ctr_next = high_ctr_reg;
        low_ctr_next  = low_ctr_reg;
        publish       = 1'b0;
        if (timeout_fire) begin
            high_ctr_next = '0;
            low_ctr_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rise_reg) begin
                        high_ctr_next = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall_reg) begin
                        low_ctr_next = CNT_ONE;
                    end else if (high_ctr_reg != CNT_MAX) begin
                        high_ctr_next = high_ctr_reg + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise_reg) begin
                        publish       = 1'b1;
                        high_ctr_next = CNT_ONE;
                    end else if (low_ctr_reg != CNT_MAX) begin
                        low_ctr_next = low_ctr_reg + 1'b1;
                    end
                end
                default: begin
                    high_ctr_next = '0;
                    low_ctr_next  = '0;
                end
            endcase
        end
    end

    // Running high / low counters
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            high_ctr_reg <= '0;
            low_ctr_reg  <= '0;
        end else begin
            high_ctr_reg <= high_ctr_next;
            low_ctr_reg  <= low_ctr_next;
        end
    end

    // Saturating period = high + low
    assign period_sum = {1'b0, high_ctr_reg} + {1'b0, low_ctr_reg};
    assign period_sat = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];

    // Duty level decode of the low time being published
    pwm_isqrt #(
        .CNT_W (CNT_W)
    ) u_isqrt (
        .x    (low_ctr_reg),
        .root (level_calc)
    );

    // Result registers: updated on publish, level forced on a stuck line
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            period_reg     <= '0;
            high_cnt_reg   <= '0;
            low_cnt_reg    <= '0;
            level_reg      <= '0;
            meas_valid_reg <= 1'b0;
        end else begin
            meas_valid_reg <= publish;
            if (publish) begin
                period_reg   <= period_sat;
                high_cnt_reg <= high_ctr_reg;
                low_cnt_reg  <= low_ctr_reg;
                level_reg    <= level_calc;
            end else if (timeout_fire) begin
                level_reg <= sync2_reg ? LVL_W'(0) : LVL_W'(15);
            end
        end
    end

    assign period     = period_reg;
    assign high_cnt   = high_cnt_reg;
    assign low_cnt    = low_cnt_reg;
    assign level      = level_reg;
    assign meas_valid = meas_valid_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: drives PWM phases of known length and
// compares published results against hand-computed values.
module tb_pwm_capture;

    localparam int CNT_W = 10;

    logic             clk_1m = 1'b0;
    logic             rst    = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [3:0]       level;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    int total = 0;
    int bad   = 0;

    // Publish monitor state
    int   pulse_cnt = 0;
    int   dbl_pulse = 0;
    logic mv_prev   = 1'b0;
    int   cap_period, cap_high, cap_low, cap_level;
    int   np;

    always #5 clk_1m = ~clk_1m;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk_1m      (clk_1m),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .level       (level),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    // Capture results on every meas_valid pulse; flag pulses longer than one cycle
    always @(negedge clk_1m) begin
        if (meas_valid) begin
            pulse_cnt  = pulse_cnt + 1;
            cap_period = int'(period);
            cap_high   = int'(high_cnt);
            cap_low    = int'(low_cnt);
            cap_level  = int'(level);
            if (mv_prev) dbl_pulse = dbl_pulse + 1;
        end
        mv_prev = meas_valid;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("pass %s value=%0d", tag, got);
        end
    endtask

    task automatic phase(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk_1m);
    endtask

    task automatic chk_pub(input string tag, input int exp_n, input int exp_p,
                           input int exp_h, input int exp_l, input int exp_lv);
        chk({tag, "_pulses"}, pulse_cnt,  exp_n);
        chk({tag, "_period"}, cap_period, exp_p);
        chk({tag, "_high"},   cap_high,   exp_h);
        chk({tag, "_low"},    cap_low,    exp_l);
        chk({tag, "_level"},  cap_level,  exp_lv);
    endtask

    initial begin
        // Reset state
        rst    = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk_1m);
        #1;
        chk("rst_period",      int'(period),      0);
        chk("rst_high",        int'(high_cnt),    0);
        chk("rst_low",         int'(low_cnt),     0);
        chk("rst_level",       int'(level),       0);
        chk("rst_meas_valid",  int'(meas_valid),  0);
        chk("rst_stuck",       int'(stuck),       0);
        chk("rst_stuck_level", int'(stuck_level), 0);
        @(negedge clk_1m);
        rst = 1'b1;

        // Period 256: low 9 / high 247, starting low; first rise must not publish
        phase(1'b0, 20);
        phase(1'b1, 247);
        phase(1'b0, 9);
        chk("no_pub_first", pulse_cnt, 0);
        phase(1'b1, 247);
        chk_pub("p256", 1, 256, 247, 9, 3);

        // Level boundaries: low 225 -> 15, low 224 -> 14
        phase(1'b0, 225);
        phase(1'b1, 31);
        chk_pub("low225", 2, 472, 247, 225, 15);
        phase(1'b0, 224);
        phase(1'b1, 20);
        chk_pub("low224", 3, 255, 31, 224, 14);

        // Results hold between publishes
        phase(1'b1, 10);
        chk("hold_period", int'(period),     255);
        chk("hold_level",  int'(level),      14);
        chk("hold_mv",     int'(meas_valid), 0);
        np = 3;

`ifndef PWM_CAPTURE_TIMEOUT_EN
        // Saturation: high phase well beyond 1023 cycles
        phase(1'b1, 1200);
        phase(1'b0, 50);
        phase(1'b1, 20);
        np = np + 1;
        chk_pub("sat", np, 1023, 1023, 50, 7);
`endif

        // Reset mid high phase
        phase(1'b0, 30);
        phase(1'b1, 40);
        np = np + 1;
        chk("pre_rst_pulses", pulse_cnt, np);
        rst = 1'b0;
        #1;
        chk("midrst_period", int'(period),     0);
        chk("midrst_high",   int'(high_cnt),   0);
        chk("midrst_low",    int'(low_cnt),    0);
        chk("midrst_level",  int'(level),      0);
        chk("midrst_mv",     int'(meas_valid), 0);
        chk("midrst_stuck",  int'(stuck),      0);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk_1m);
        rst = 1'b1;
        phase(1'b0, 10);
        phase(1'b1, 100);
        phase(1'b0, 16);
        chk("post_rst_no_pub", pulse_cnt, np);
        phase(1'b1, 20);
        np = np + 1;
        chk_pub("post_rst", np, 116, 100, 16, 4);

`ifdef PWM_CAPTURE_TIMEOUT_EN
        // Line held high past the timeout
        phase(1'b1, 1000);
        chk("stuck_flag",   int'(stuck),       1);
        chk("stuck_lvl",    int'(stuck_level), 1);
        chk("stuck_level0", int'(level),       0);
        chk("stuck_no_pub", pulse_cnt,         np);
        chk("stuck_hold_p", int'(period),      116);
        // Recovery: stuck clears only at the next publish
        phase(1'b0, 30);
        phase(1'b1, 30);
        chk("stuck_kept", int'(stuck), 1);
        phase(1'b0, 30);
        phase(1'b1, 20);
        np = np + 1;
        chk_pub("recover", np, 60, 30, 30, 5);
        chk("stuck_clear", int'(stuck), 0);
`else
        // Without the timer the flags stay low however long the line is idle
        phase(1'b1, 1000);
        chk("nostuck_flag",  int'(stuck),       0);
        chk("nostuck_lvl",   int'(stuck_level), 0);
        chk("nostuck_pub",   pulse_cnt,         np);
        chk("nostuck_level", int'(level),       4);
`endif

        chk("single_cycle_mv", dbl_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
